muldiv_seq: RTL and testbench

Parametrised iterative integer multiply/divide unit: the successor to the separate fixed 32-bit multiplier and divider that hang off the RISC5 datapath. It provides one shared shift/add-subtract engine with a configurable operand width. It supports signed and unsigned multiply and Euclidean division, and reports divide-by-zero explicitly. It keeps the CPU-side `run`/`stall` handshake, so it drops into the ALU result mux and the stall OR-tree unchanged.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_seq.sv | 162 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// CPU-side run/stall handshake and operand/result bus of the iterative multiply/divide unit.
// The CPU owns the master side; the arithmetic unit owns the slave side.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             run;
    logic             op;
    logic             sgn;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             stall;
    logic [WIDTH-1:0] zlo;
    logic [WIDTH-1:0] zhi;
    logic             dz;

    modport master (
        output run, op, sgn, x, y,
        input  stall, zlo, zhi, dz
    );

    modport slave (
        input  run, op, sgn, x, y,
        output stall, zlo, zhi, dz
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 signed/unsigned multiply and Euclidean divide sharing one shift/add-subtract
// engine; one step per cycle, results registered on completion, stall driven combinationally.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           op_q;
    logic           xneg_q;
    logic           sign_q;
    logic           dz_pend;
    logic [W-1:0]   acc_hi;
    logic [W-1:0]   acc_lo;
    logic [W-1:0]   mag_b;
    logic [W-1:0]   zlo_q;
    logic [W-1:0]   zhi_q;
    logic           dz_q;

    // operand conditioning at start
    logic           x_neg_c;
    logic           y_neg_c;
    logic [W-1:0]   x_mag_c;
    logic [W-1:0]   y_mag_c;
    logic           y_zero_c;

    // one engine step
    logic [W:0]     mul_sum_c;
    logic [W:0]     div_sh_c;
    logic           div_ge_c;
    logic [W-1:0]   div_diff_c;
    logic [W-1:0]   step_hi_c;
    logic [W-1:0]   step_lo_c;

    // sign fix-up applied to the final step
    logic [W2-1:0]  prod_c;
    logic [W2-1:0]  prod_fix_c;
    logic           rem_nz_c;
    logic           adj_c;
    logic [W-1:0]   div_q_c;
    logic [W-1:0]   div_r_c;
    logic [W-1:0]   q_fix_c;
    logic [W-1:0]   res_lo_c;
    logic [W-1:0]   res_hi_c;

    always_comb begin
        x_neg_c  = bus.sgn & bus.x[W-1];
        y_neg_c  = bus.sgn & bus.y[W-1];
        x_mag_c  = x_neg_c ? W'(-bus.x) : bus.x;
        y_mag_c  = y_neg_c ? W'(-bus.y) : bus.y;
        y_zero_c = (bus.y == '0);
    end

    // Multiply: shift-right add of the multiplicand. Divide: restoring shift-left subtract.
    // The partial remainder is always below the divisor, so the W-bit difference is exact.
    always_comb begin
        mul_sum_c  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_b : {W{1'b0}})};
        div_sh_c   = {acc_hi, acc_lo[W-1]};
        div_ge_c   = (div_sh_c >= {1'b0, mag_b});
        div_diff_c = div_sh_c[W-1:0] - mag_b;
        if (op_q) begin
            step_hi_c = div_ge_c ? div_diff_c : div_sh_c[W-1:0];
            step_lo_c = {acc_lo[W-2:0], div_ge_c};
        end else begin
            step_hi_c = mul_sum_c[W:1];
            step_lo_c = {mul_sum_c[0], acc_lo[W-1:1]};
        end
    end

    // Euclidean correction: a negative dividend with nonzero remainder bumps |q| and folds r.
    always_comb begin
        prod_c     = {step_hi_c, step_lo_c};
        prod_fix_c = sign_q ? W2'(-prod_c) : prod_c;
        rem_nz_c   = (step_hi_c != '0);
        adj_c      = xneg_q & rem_nz_c;
        div_q_c    = adj_c ? W'(step_lo_c + W'(1)) : step_lo_c;
        div_r_c    = adj_c ? W'(mag_b - step_hi_c) : step_hi_c;
        q_fix_c    = sign_q ? W'(-div_q_c) : div_q_c;
        res_lo_c   = op_q ? q_fix_c : prod_fix_c[W-1:0];
        res_hi_c   = op_q ? div_r_c : prod_fix_c[W2-1:W];
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= 1'b0;
            xneg_q  <= 1'b0;
            sign_q  <= 1'b0;
            dz_pend <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mag_b   <= '0;
            zlo_q   <= '0;
            zhi_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        op_q    <= bus.op;
                        xneg_q  <= x_neg_c;
                        sign_q  <= x_neg_c ^ y_neg_c;
                        dz_pend <= bus.op & y_zero_c;
                        // acc_hi carries the raw dividend through a divide by zero
                        acc_hi  <= (bus.op & y_zero_c) ? bus.x : '0;
                        acc_lo  <= bus.op ? x_mag_c : y_mag_c;
                        mag_b   <= bus.op ? y_mag_c : x_mag_c;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.run) begin
                        state <= IDLE;
                    end else if (dz_pend) begin
                        zlo_q <= '1;
                        zhi_q <= acc_hi;
                        dz_q  <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc_hi <= step_hi_c;
                        acc_lo <= step_lo_c;
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(W - 1)) begin
                            zlo_q <= res_lo_c;
                            zhi_q <= res_hi_c;
                            dz_q  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall = bus.run & ((state == IDLE) | (state == BUSY));
    assign bus.zlo   = zlo_q;
    assign bus.zhi   = zhi_q;
    assign bus.dz    = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, randomized ops against an
// arithmetic reference model, plus reset-abort and run-drop sequences at WIDTH 32 and 8.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run32;
    logic        run8;
    logic        op;
    logic        sgn;
    logic [31:0] xin;
    logic [31:0] yin;
    bit          use8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) b32 ();
    muldiv_if #(.WIDTH(8))  b8  ();

    assign b32.run = run32;
    assign b32.op  = op;
    assign b32.sgn = sgn;
    assign b32.x   = xin;
    assign b32.y   = yin;
    assign b8.run  = run8;
    assign b8.op   = op;
    assign b8.sgn  = sgn;
    assign b8.x    = xin[7:0];
    assign b8.y    = yin[7:0];

    muldiv_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    muldiv_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    typedef struct {
        string       name;
        bit          op;
        bit          sgn;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] lo;
        logic [31:0] hi;
        bit          dz;
        int          cyc;
    } vec_t;

    vec_t tbl[11];

    function automatic logic stall_now();
        return use8 ? b8.stall : b32.stall;
    endfunction

    function automatic logic [31:0] cur_lo();
        return use8 ? {24'b0, b8.zlo} : b32.zlo;
    endfunction

    function automatic logic [31:0] cur_hi();
        return use8 ? {24'b0, b8.zhi} : b32.zhi;
    endfunction

    function automatic logic cur_dz();
        return use8 ? b8.dz : b32.dz;
    endfunction

    // Reference: plain integer arithmetic on sign-extended operands, Euclidean fix of the
    // truncating SV division for signed divides.
    function automatic void model(input int w, input bit o, input bit s,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output bit z, output int cyc);
        longint unsigned mask, am, bm, pu;
        longint sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'b0, a} & mask;
        bm   = {32'b0, b} & mask;
        sa   = longint'(am);
        sb   = longint'(bm);
        if (s && am[w-1]) sa = sa - (longint'(1) << w);
        if (s && bm[w-1]) sb = sb - (longint'(1) << w);
        z   = 1'b0;
        cyc = w + 1;
        if (!o) begin
            p  = sa * sb;
            pu = $unsigned(p);
            lo = 32'(pu & mask);
            hi = 32'((pu >> w) & mask);
        end else if (bm == 64'd0) begin
            lo  = 32'(mask);
            hi  = 32'(am);
            z   = 1'b1;
            cyc = 2;
        end else begin
            q = sa / sb;
            r = sa % sb;
            if (r < 0) begin
                if (sb > 0) begin q = q - 1; r = r + sb; end
                else        begin q = q + 1; r = r - sb; end
            end
            lo = 32'($unsigned(q) & mask);
            hi = 32'($unsigned(r) & mask);
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_run(input bit v);
        if (use8) run8 = v;
        else      run32 = v;
    endtask

    // Counts stall-high cycles until results are valid; bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (stall_now() && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic start_op(input bit o, input bit s, input logic [31:0] a,
                            input logic [31:0] b, output int cyc);
        op  = o;
        sgn = s;
        xin = a;
        yin = b;
        set_run(1'b1);
        #1;
        if (!stall_now()) begin
            @(posedge clk); #1;
        end
        wait_done(cyc);
    endtask

    task automatic apply(input string name, input bit o, input bit s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input bit edz, input int ecyc);
        int cyc;
        start_op(o, s, a, b, cyc);
        check({name, ".cyc"}, 64'(cyc), 64'(ecyc));
        check({name, ".lo"},  64'(cur_lo()), 64'(elo));
        check({name, ".hi"},  64'(cur_hi()), 64'(ehi));
        check({name, ".dz"},  64'(cur_dz()), 64'(edz));
    endtask

    task automatic go_idle();
        run32 = 1'b0;
        run8  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rand_ops(input int w, input int n);
        logic [31:0] specials[6];
        logic [31:0] a, b, elo, ehi;
        bit          o, s, edz;
        int          ecyc;
        specials[0] = 32'h0;
        specials[1] = 32'h1;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = (w == 8) ? 32'h80 : 32'h8000_0000;
        specials[4] = (w == 8) ? 32'h7F : 32'h7FFF_FFFF;
        specials[5] = 32'h7;
        for (int i = 0; i < n; i++) begin
            o = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 9) == 0) b = 32'h0;
            if ($urandom_range(0, 2) == 0) b = b & 32'h0000_000F;
            model(w, o, s, a, b, elo, ehi, edz, ecyc);
            apply($sformatf("rnd%0d_%0d", w, i), o, s, a, b, elo, ehi, edz, ecyc);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
    endtask

    initial begin
        int cyc;
        tbl[0]  = '{"mul_s_7x-3",   1'b0, 1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 33};
        tbl[1]  = '{"mul_u_max",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33};
        tbl[2]  = '{"mul_u_3x5",    1'b0, 1'b0, 32'd3,         32'd5,         32'd15,        32'd0,         1'b0, 33};
        tbl[3]  = '{"div_s_-7/2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFC, 32'd1,         1'b0, 33};
        tbl[4]  = '{"div_s_-7/-2",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd4,         32'd1,         1'b0, 33};
        tbl[5]  = '{"div_s_ovf",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 33};
        tbl[6]  = '{"div_s_7/-2",   1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 33};
        tbl[7]  = '{"div_u_5/0",    1'b1, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 2};
        tbl[8]  = '{"mul_u_2x2",    1'b0, 1'b0, 32'd2,         32'd2,         32'd4,         32'd0,         1'b0, 33};
        tbl[9]  = '{"div_s_min/0",  1'b1, 1'b1, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 2};
        tbl[10] = '{"div_u_100/7",  1'b1, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33};

        rst   = 1'b0;
        run32 = 1'b0;
        run8  = 1'b0;
        op    = 1'b0;
        sgn   = 1'b0;
        xin   = '0;
        yin   = '0;
        use8  = 1'b0;

        #1;
        check("rst.zlo",   64'(b32.zlo), 64'h0);
        check("rst.zhi",   64'(b32.zhi), 64'h0);
        check("rst.dz",    64'(b32.dz),  64'h0);
        check("rst.stall0", 64'(b32.stall), 64'h0);
        run32 = 1'b1;
        #1;
        check("rst.stall1", 64'(b32.stall), 64'h1);
        run32 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table, issued back-to-back.
        foreach (tbl[i])
            apply(tbl[i].name, tbl[i].op, tbl[i].sgn, tbl[i].x, tbl[i].y,
                  tbl[i].lo, tbl[i].hi, tbl[i].dz, tbl[i].cyc);
        go_idle();

        rand_ops(32, 50);

        // Asynchronous reset in the middle of a divide, then a fresh op with run held high.
        apply("pre_rst", 1'b0, 1'b0, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 33);
        go_idle();
        op = 1'b1; sgn = 1'b0; xin = 32'd1000; yin = 32'd3;
        run32 = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst.zlo",   64'(b32.zlo),   64'h0);
        check("arst.zhi",   64'(b32.zhi),   64'h0);
        check("arst.dz",    64'(b32.dz),    64'h0);
        check("arst.stall", 64'(b32.stall), 64'h1);
        xin = 32'd100; yin = 32'd7;
        @(posedge clk); #1;
        rst = 1'b1;
        wait_done(cyc);
        check("post_rst.cyc", 64'(cyc), 64'd33);
        check("post_rst.lo",  64'(b32.zlo), 64'd14);
        check("post_rst.hi",  64'(b32.zhi), 64'd2);
        check("post_rst.dz",  64'(b32.dz),  64'd0);
        go_idle();

        // WIDTH 8 instance.
        use8 = 1'b1;
        apply("w8_200/7", 1'b1, 1'b0, 32'd200, 32'd7, 32'd28, 32'd4, 1'b0, 9);
        go_idle();

        // Drop run at BUSY cycle 3; a new op must start from IDLE on the following cycle.
        op = 1'b1; sgn = 1'b0; xin = 32'd100; yin = 32'd3;
        run8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run8 = 1'b0;
        #1;
        check("abort.stall", 64'(b8.stall), 64'h0);
        @(posedge clk); #1;
        check("abort.lo", 64'(b8.zlo), 64'd28);
        check("abort.hi", 64'(b8.zhi), 64'd4);
        apply("w8_after_abort", 1'b1, 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 9);
        go_idle();

        // Abort again and linger: outputs must keep the last completed result.
        op = 1'b0; sgn = 1'b0; xin = 32'd9; yin = 32'd9;
        run8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run8 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort2.lo", 64'(b8.zlo), 64'd10);
        check("abort2.hi", 64'(b8.zhi), 64'd0);
        check("abort2.dz", 64'(b8.dz),  64'd0);

        rand_ops(8, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
